// File: rtl/pipe_hazard_if.sv
// Hazard-controller bundle: pipeline hazard sources in, stage controls and
// performance counters out. The master side is the pipeline, the slave side is the controller.
interface pipe_hazard_if #(
  parameter int CNT_W = 16
);
  logic             id_ex_memread;
  logic [4:0]       id_ex_rd;
  logic [4:0]       if_id_rs1;
  logic [4:0]       if_id_rs2;
  logic             rs1_used;
  logic             rs2_used;
  logic             branch_taken;
  logic             imem_ready;
  logic             dmem_ready;

  logic             pc_write;
  logic             if_id_write;
  logic             if_flush;
  logic             id_ex_bubble;
  logic             pipe_freeze;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_ex_memread, id_ex_rd, if_id_rs1, if_id_rs2, rs1_used, rs2_used,
           branch_taken, imem_ready, dmem_ready,
    input  pc_write, if_id_write, if_flush, id_ex_bubble, pipe_freeze,
           mem_timeout, stall_cycles, flush_count
  );

  modport slave (
    input  id_ex_memread, id_ex_rd, if_id_rs1, if_id_rs2, rs1_used, rs2_used,
           branch_taken, imem_ready, dmem_ready,
    output pc_write, if_id_write, if_flush, id_ex_bubble, pipe_freeze,
           mem_timeout, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: prioritises data-memory freeze,
// redirects, load-use bubbles and fetch waits; tracks wait timeout and counters.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic           clk,
  input  logic           rst,
  pipe_hazard_if.slave   bus
);
  localparam int WC_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    IMEM_WAIT = 2'd1,
    DMEM_WAIT = 2'd2
  } state_t;

  state_t            state_reg;
  state_t            state_next;
  logic              redirect_pend_reg;
  logic              redirect_pend_next;
  logic [WC_W-1:0]   wait_cnt_reg;
  logic [WC_W-1:0]   wait_cnt_base;
  logic              mem_timeout_reg;
  logic [CNT_W-1:0]  stall_cycles_reg;
  logic [CNT_W-1:0]  flush_count_reg;

  logic              load_use;
  logic              redirect;
  logic              flush_inc;
  logic              pc_write_c;
  logic              if_id_write_c;
  logic              if_flush_c;
  logic              id_ex_bubble_c;
  logic              pipe_freeze_c;

  assign load_use = bus.id_ex_memread && (bus.id_ex_rd != 5'd0) &&
                    ((bus.rs1_used && (bus.id_ex_rd == bus.if_id_rs1)) ||
                     (bus.rs2_used && (bus.id_ex_rd == bus.if_id_rs2)));

  assign redirect = bus.branch_taken || redirect_pend_reg;

  always_comb begin
    pc_write_c         = 1'b0;
    if_id_write_c      = 1'b0;
    if_flush_c         = 1'b0;
    id_ex_bubble_c     = 1'b0;
    pipe_freeze_c      = 1'b0;
    flush_inc          = 1'b0;
    state_next         = RUN;
    redirect_pend_next = redirect_pend_reg;

    if (!bus.dmem_ready) begin
      // Whole back end is held; a branch resolving now must survive the freeze.
      pipe_freeze_c = 1'b1;
      state_next    = DMEM_WAIT;
      if (bus.branch_taken) begin
        redirect_pend_next = 1'b1;
      end
    end else if (redirect) begin
      if_flush_c     = 1'b1;
      id_ex_bubble_c = 1'b1;
      if (bus.imem_ready) begin
        pc_write_c         = 1'b1;
        redirect_pend_next = 1'b0;
        flush_inc          = 1'b1;
      end else begin
        redirect_pend_next = 1'b1;
        state_next         = IMEM_WAIT;
      end
    end else if (load_use) begin
      id_ex_bubble_c = 1'b1;
    end else if (!bus.imem_ready) begin
      id_ex_bubble_c = 1'b1;
      state_next     = IMEM_WAIT;
    end else begin
      pc_write_c    = 1'b1;
      if_id_write_c = 1'b1;
    end

    if (rst) begin
      pc_write_c     = 1'b0;
      if_id_write_c  = 1'b0;
      if_flush_c     = 1'b1;
      id_ex_bubble_c = 1'b1;
      pipe_freeze_c  = 1'b0;
    end
  end

  // A wait run continues only while the same memory keeps stalling.
  assign wait_cnt_base = (state_next == state_reg) ? wait_cnt_reg : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= RUN;
      redirect_pend_reg <= 1'b0;
      wait_cnt_reg      <= '0;
      mem_timeout_reg   <= 1'b0;
      stall_cycles_reg  <= '0;
      flush_count_reg   <= '0;
    end else begin
      state_reg         <= state_next;
      redirect_pend_reg <= redirect_pend_next;
      if (state_next == RUN) begin
        wait_cnt_reg <= '0;
      end else begin
        if (wait_cnt_base == WC_MAX) begin
          mem_timeout_reg <= 1'b1;
        end else begin
          wait_cnt_reg <= wait_cnt_base + 1'b1;
        end
      end
      if (!pc_write_c && (stall_cycles_reg != '1)) begin
        stall_cycles_reg <= stall_cycles_reg + 1'b1;
      end
      if (flush_inc && (flush_count_reg != '1)) begin
        flush_count_reg <= flush_count_reg + 1'b1;
      end
    end
  end

  assign bus.pc_write     = pc_write_c;
  assign bus.if_id_write  = if_id_write_c;
  assign bus.if_flush     = if_flush_c;
  assign bus.id_ex_bubble = id_ex_bubble_c;
  assign bus.pipe_freeze  = pipe_freeze_c;
  assign bus.mem_timeout  = mem_timeout_reg;
  assign bus.stall_cycles = stall_cycles_reg;
  assign bus.flush_count  = flush_count_reg;
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage core.
- Drives the IF/ID register controls (active-high write enable, flush), PC write enable, ID/EX bubble insertion and a global freeze.
- Sources:
  - load-use hazards;
  - taken branches/jumps resolved in EX;
  - instruction-memory and data-memory wait states.
- Keeps a pending-redirect flag, a wait timeout and saturating performance counters.

Parameters:
- TIMEOUT, 64: consecutive memory-wait cycles before mem_timeout asserts (≥2).
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  clock; state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- id_ex_memread  in  1  instruction in EX is a load.
- id_ex_rd  in  5  load destination register.
- if_id_rs1  in  5  source register 1 of instruction in ID.
- if_id_rs2  in  5  source register 2 of instruction in ID.
- rs1_used  in  1  ID instruction reads rs1.
- rs2_used  in  1  ID instruction reads rs2.
- branch_taken  in  1  EX resolved taken branch or jump; redirect PC valid this cycle.
- imem_ready  in  1  fetch data valid this cycle.
- dmem_ready  in  1  data-memory access complete; tie 1 when MEM holds no access.
- pc_write  out  1  PC register write enable.
- if_id_write  out  1  IF/ID write enable (1 = load).
- if_flush  out  1  IF/ID clear to zero.
- id_ex_bubble  out  1  force ID/EX control fields to zero.
- pipe_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB.
- mem_timeout  out  1  sticky error.
- stall_cycles  out  CNT_W  cycles with pc_write = 0.
- flush_count  out  CNT_W  flushes issued.

Behaviour:
- State register: {RUN, IMEM_WAIT, DMEM_WAIT}, plus redirect_pend, wait_cnt, mem_timeout and both counters.
- Reset: state = RUN, redirect_pend = 0, wait_cnt = 0, mem_timeout = 0, counters = 0.
- All outputs are combinational from registered state and current inputs.
- While rst = 1: pc_write = 0, if_id_write = 0, if_flush = 1, id_ex_bubble = 1, pipe_freeze = 0.
- Load-use hazard, lu: id_ex_memread && id_ex_rd != 0 && ((rs1_used && rd == rs1) || (rs2_used && rd == rs2)).
- Per-cycle priority, highest first:
  1. DMEM: dmem_ready = 0 → pipe_freeze = 1, pc_write = 0, if_id_write = 0, if_flush = 0, id_ex_bubble = 0. State = DMEM_WAIT. If branch_taken, set redirect_pend.
  2. Redirect: branch_taken or redirect_pend.
     - If imem_ready: if_flush = 1, id_ex_bubble = 1, pc_write = 1, if_id_write = 0. Clear redirect_pend; flush_count += 1.
     - Else: set/hold redirect_pend, pc_write = 0, if_id_write = 0, if_flush = 1. State = IMEM_WAIT.
  3. Load-use: lu → pc_write = 0, if_id_write = 0, id_ex_bubble = 1. Exactly one bubble per hazard; the next cycle re-evaluates.
  4. IMEM: imem_ready = 0 → pc_write = 0, if_id_write = 0, id_ex_bubble = 1. State = IMEM_WAIT.
  5. Else: pc_write = 1, if_id_write = 1, all others 0. State = RUN.
- Transitions:
  - IMEM_WAIT/DMEM_WAIT → RUN in the first cycle the respective ready = 1.
  - DMEM_WAIT with imem_ready = 0 on release → IMEM_WAIT.
- wait_cnt:
  - Increments each cycle the state is a WAIT and ready = 0; reset to 0 on any ready or RUN.
  - At wait_cnt == TIMEOUT-1 with ready still 0, mem_timeout ← 1 (sticky until rst).
  - Stalling continues after the timeout.
- Counters:
  - stall_cycles += 1 when pc_write = 0 (outside reset).
  - Both counters saturate at all-ones, no wrap.
- Simultaneous events:
  - A branch during a DMEM freeze is captured in redirect_pend, never lost.
  - Branch plus lu: the flush wins, no load-use bubble counted.
  - rst mid-wait: all state cleared the next edge, redirect_pend dropped.

Test Plan:
- Load-use: id_ex_memread = 1, id_ex_rd = 5, if_id_rs2 = 5, rs2_used = 1 → one cycle of pc_write = 0, if_id_write = 0, id_ex_bubble = 1; stall_cycles = 1. Same with rd = 0 → no stall.
- Branch: branch_taken = 1, imem_ready = 1 → if_flush = 1, id_ex_bubble = 1, pc_write = 1 for that cycle; flush_count = 1.
- Branch during dmem wait: dmem_ready = 0 for 3 cycles, branch_taken pulse in cycle 1, then dmem_ready = 1 → pipe_freeze = 1 for 3 cycles, then a single flush cycle; flush_count = 1.
- Timeout: TIMEOUT = 4, imem_ready = 0 for 6 cycles → mem_timeout rises after the 4th wait cycle and stays 1 after imem_ready returns; clears only on rst.
- Saturation: CNT_W = 3, 10 imem stall cycles → stall_cycles = 7.
- Reset mid-wait: rst during DMEM_WAIT with redirect_pend = 1 → next cycle state RUN, all counters 0, no flush issued afterwards.
